// File: rtl/byte_bus_arbiter.sv
// rtl/byte_bus_arbiter.sv - two-port round-robin arbiter onto an 8-bit byte-serial memory bus
module byte_bus_arbiter #(
  parameter int TURNAROUND = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [7:0]  bus_addr,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din,
  output logic [7:0]  bus_oe,
  output logic [1:0]  bus_phase,
  output logic [1:0]  bus_byte
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_TURN,
    S_RDATA,
    S_DONE
  } state_t;

  localparam logic [1:0] TURN_LAST = 2'((TURNAROUND == 0) ? 0 : TURNAROUND - 1);

  state_t      state_q, state_d;
  logic [1:0]  byte_q, byte_d;
  logic [1:0]  turn_q, turn_d;
  logic        port_q, port_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      byte_q  <= 2'd0;
      turn_q  <= 2'd0;
      port_q  <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      turn_q  <= turn_d;
      port_q  <= port_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    turn_d  = turn_q;
    port_d  = port_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    win     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // On a tie the port that was not served last wins
          win     = (req0 && req1) ? ~last_q : req1;
          port_d  = win;
          we_d    = win ? we1 : we0;
          addr_d  = win ? addr1 : addr0;
          wdata_d = win ? wdata1 : wdata0;
          byte_d  = 2'd0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (byte_q == 2'd3) begin
          byte_d = 2'd0;
          turn_d = 2'd0;
          if (we_q) begin
            state_d = S_DONE;
          end else if (TURNAROUND == 0) begin
            state_d = S_RDATA;
          end else begin
            state_d = S_TURN;
          end
        end else begin
          byte_d = byte_q + 2'd1;
        end
      end
      S_TURN: begin
        if (turn_q == TURN_LAST) begin
          byte_d  = 2'd0;
          state_d = S_RDATA;
        end else begin
          turn_d = turn_q + 2'd1;
        end
      end
      S_RDATA: begin
        rdata_d[{byte_q, 3'b000} +: 8] = bus_din;
        if (byte_q == 2'd3) begin
          byte_d  = 2'd0;
          state_d = S_DONE;
        end else begin
          byte_d = byte_q + 2'd1;
        end
      end
      S_DONE: begin
        last_d  = port_q;
        byte_d  = 2'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin outputs decode from reset-cleared state, so they drop the instant rst_n falls
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    bus_addr  = 8'd0;
    bus_dout  = 8'd0;
    bus_oe    = 8'd0;
    bus_phase = 2'd0;
    bus_byte  = 2'd0;
    case (state_q)
      S_ADDR: begin
        gnt0      = ~port_q;
        gnt1      = port_q;
        bus_phase = 2'd1;
        bus_byte  = byte_q;
        bus_addr  = addr_q[{byte_q, 3'b000} +: 8];
        if (we_q) begin
          bus_dout = wdata_q[{byte_q, 3'b000} +: 8];
          bus_oe   = 8'hFF;
        end
      end
      S_TURN: begin
        gnt0      = ~port_q;
        gnt1      = port_q;
        bus_phase = 2'd2;
        bus_addr  = addr_q[31:24];
      end
      S_RDATA: begin
        gnt0      = ~port_q;
        gnt1      = port_q;
        bus_phase = 2'd3;
        bus_byte  = byte_q;
      end
      S_DONE: begin
        done0 = ~port_q;
        done1 = port_q;
      end
      default: ;
    endcase
  end

  assign rdata = rdata_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_byte_bus_arbiter.sv
// tb/tb_byte_bus_arbiter.sv - scoreboard bench for byte_bus_arbiter
module tb_byte_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, done0, done1, busy;
  logic [31:0] rdata;
  logic [7:0]  bus_addr, bus_dout, bus_din, bus_oe;
  logic [1:0]  bus_phase, bus_byte;
  logic [7:0]  din_seed = 8'h00;

  logic        t0_req = 1'b0;
  logic        n_gnt0, n_gnt1, n_done0, n_done1, n_busy;
  logic [31:0] n_rdata;
  logic [7:0]  n_bus_addr, n_bus_dout, n_bus_din, n_bus_oe;
  logic [1:0]  n_bus_phase, n_bus_byte;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_bus_q[$];
  logic [31:0] exp_rd_q[$];
  int          exp_port_q[$];
  logic [31:0] exp_rdata = '0;

  always #5 clk = ~clk;

  // Memory model returns seed ^ 11,22,33,44 for read byte 0..3
  assign bus_din   = din_seed ^ (8'h11 * ({6'd0, bus_byte} + 8'd1));
  assign n_bus_din = din_seed ^ (8'h11 * ({6'd0, n_bus_byte} + 8'd1));

  byte_bus_arbiter #(.TURNAROUND(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .busy(busy),
    .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_din(bus_din),
    .bus_oe(bus_oe), .bus_phase(bus_phase), .bus_byte(bus_byte)
  );

  byte_bus_arbiter #(.TURNAROUND(0)) dut_t0 (
    .clk(clk), .rst_n(rst_n),
    .req0(t0_req), .req1(1'b0), .we0(we0), .we1(1'b0),
    .addr0(addr0), .addr1(32'd0), .wdata0(wdata0), .wdata1(32'd0),
    .gnt0(n_gnt0), .gnt1(n_gnt1), .done0(n_done0), .done1(n_done1),
    .rdata(n_rdata), .busy(n_busy),
    .bus_addr(n_bus_addr), .bus_dout(n_bus_dout), .bus_din(n_bus_din),
    .bus_oe(n_bus_oe), .bus_phase(n_bus_phase), .bus_byte(n_bus_byte)
  );

  function automatic logic [31:0] exp_rd(input logic [7:0] s);
    return {s ^ 8'h44, s ^ 8'h33, s ^ 8'h22, s ^ 8'h11};
  endfunction

  task automatic push_bus(input logic [31:0] a, input logic [31:0] d, input logic wr);
    for (int k = 0; k < 4; k++)
      exp_bus_q.push_back({6'd0, 2'(k), a[8*k +: 8], wr ? d[8*k +: 8] : 8'h00, wr ? 8'hFF : 8'h00});
  endtask

  task automatic wait_done(output int lat, output int port);
    lat  = -1;
    port = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done0 || done1) begin
        lat  = i - 1;
        port = done1 ? 1 : 0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({gnt0, gnt1, done0, done1, busy, bus_oe, bus_phase, bus_byte, bus_addr, bus_dout, rdata} !== 65'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", {gnt0, gnt1, done0, done1, busy, bus_oe, bus_phase, bus_byte, bus_addr, bus_dout, rdata});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, gnt0, gnt1, n_busy} !== 4'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: busy/gnt got %b want 0000", {busy, gnt0, gnt1, n_busy});
    end
    exp_rdata = '0;
  endtask

  task automatic test_single_write;
    int lat, port;
    logic [31:0] e;
    lat = -1; port = -1;
    addr0 = 32'h12345678; wdata0 = 32'hA1B2C3D4; we0 = 1'b1; req0 = 1'b1;
    push_bus(addr0, wdata0, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus_phase == 2'd1) begin
        e = (exp_bus_q.size() > 0) ? exp_bus_q.pop_front() : 32'hFFFFFFFF;
        n_cmp++;
        if ({6'd0, bus_byte, bus_addr, bus_dout, bus_oe} !== e) begin
          n_err++;
          $display("FAIL write_bus_byte: got %h want %h", {6'd0, bus_byte, bus_addr, bus_dout, bus_oe}, e);
        end
      end
      if (done0 || done1) begin
        lat = i - 1; port = done1 ? 1 : 0; req0 = 1'b0;
        break;
      end
    end
    n_cmp++;
    if (lat !== 4 || port !== 0 || exp_bus_q.size() != 0) begin
      n_err++;
      $display("FAIL write_done: latency %0d port %0d left %0d want 4 0 0", lat, port, exp_bus_q.size());
    end
    n_cmp++;
    if (rdata !== exp_rdata) begin
      n_err++;
      $display("FAIL write_rdata_untouched: got %h want %h", rdata, exp_rdata);
    end
    exp_bus_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_read;
    int lat, port, turns, bad_oe;
    logic [31:0] e;
    lat = -1; port = -1; turns = 0; bad_oe = 0;
    din_seed = 8'h00;
    addr1 = 32'h00000010; we1 = 1'b0; req1 = 1'b1;
    exp_rd_q.push_back(exp_rd(din_seed));
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus_phase == 2'd2) turns++;
      if (bus_phase != 2'd0 && bus_oe != 8'h00) bad_oe++;
      if (done0 || done1) begin
        lat = i - 1; port = done1 ? 1 : 0; req1 = 1'b0;
        break;
      end
    end
    e = exp_rd_q.pop_front();
    n_cmp++;
    if (turns !== 1 || bad_oe !== 0) begin
      n_err++;
      $display("FAIL read_turn: turn cycles %0d oe-high cycles %0d want 1 0", turns, bad_oe);
    end
    n_cmp++;
    if (lat !== 9 || port !== 1) begin
      n_err++;
      $display("FAIL read_done: latency %0d port %0d want 9 1", lat, port);
    end
    n_cmp++;
    if (rdata !== e) begin
      n_err++;
      $display("FAIL read_rdata: got %h want %h", rdata, e);
    end
    exp_rdata = e;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (rdata !== exp_rdata) begin
      n_err++;
      $display("FAIL read_rdata_hold: got %h want %h", rdata, exp_rdata);
    end
  endtask

  task automatic test_round_robin;
    int cnt, port, both, exp_p;
    both = 0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = '0;
    we0 = 1'b1; we1 = 1'b1; addr0 = 32'h100; addr1 = 32'h200;
    for (int t = 0; t < 4; t++) exp_port_q.push_back(t % 2);
    req0 = 1'b1; req1 = 1'b1;
    for (int t = 0; t < 4; t++) begin
      cnt = -1; port = -1;
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (gnt0 && gnt1) both++;
        if (done0 || done1) begin
          if (done0 && done1) both++;
          cnt = i; port = done1 ? 1 : 0;
          if (t == 3) begin req0 = 1'b0; req1 = 1'b0; end
          break;
        end
      end
      exp_p = exp_port_q.pop_front();
      n_cmp++;
      if (port !== exp_p || cnt !== ((t == 0) ? 5 : 6)) begin
        n_err++;
        $display("FAIL rr_order: txn %0d port %0d spacing %0d want %0d %0d", t, port, cnt, exp_p, (t == 0) ? 5 : 6);
      end
    end
    n_cmp++;
    if (both !== 0) begin
      n_err++;
      $display("FAIL rr_onehot: both-high cycles %0d want 0", both);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_read;
    int lat, port, dones;
    logic seen;
    seen = 1'b0; dones = 0;
    din_seed = 8'h5A;
    addr0 = 32'h00000020; we0 = 1'b0; req0 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus_phase == 2'd3 && bus_byte == 2'd2) begin seen = 1'b1; break; end
    end
    n_cmp++;
    if (seen !== 1'b1) begin
      n_err++;
      $display("FAIL midread_reach: got %b want 1", seen);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({gnt0, gnt1, done0, done1, busy, bus_oe, bus_phase, bus_byte, bus_addr, bus_dout, rdata} !== 65'd0) begin
      n_err++;
      $display("FAIL midread_async_reset: got %h want 0", {gnt0, gnt1, done0, done1, busy, bus_oe, bus_phase, bus_byte, bus_addr, bus_dout, rdata});
    end
    req0 = 1'b0;
    exp_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done0 || done1) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_err++;
      $display("FAIL midread_no_done: done pulses %0d want 0", dones);
    end
    addr0 = 32'h00000024; req0 = 1'b1;
    exp_rd_q.push_back(exp_rd(din_seed));
    wait_done(lat, port);
    req0 = 1'b0;
    exp_rdata = exp_rd_q.pop_front();
    n_cmp++;
    if (lat !== 9 || port !== 0 || rdata !== exp_rdata) begin
      n_err++;
      $display("FAIL midread_fresh_read: latency %0d port %0d rdata %h want 9 0 %h", lat, port, rdata, exp_rdata);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_req_drop;
    int lat, port;
    logic [31:0] e;
    lat = -1; port = -1;
    addr0 = 32'hCAFEF00D; wdata0 = 32'h01020304; we0 = 1'b1; req0 = 1'b1;
    push_bus(addr0, wdata0, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req0 = 1'b0; addr0 = 32'hDEADBEEF; wdata0 = 32'hFFFFFFFF; we0 = 1'b0;
      end
      if (bus_phase == 2'd1) begin
        e = (exp_bus_q.size() > 0) ? exp_bus_q.pop_front() : 32'hFFFFFFFF;
        n_cmp++;
        if ({6'd0, bus_byte, bus_addr, bus_dout, bus_oe} !== e) begin
          n_err++;
          $display("FAIL drop_bus_byte: got %h want %h", {6'd0, bus_byte, bus_addr, bus_dout, bus_oe}, e);
        end
      end
      if (done0 || done1) begin lat = i - 1; port = done1 ? 1 : 0; break; end
    end
    n_cmp++;
    if (lat !== 4 || port !== 0 || rdata !== exp_rdata) begin
      n_err++;
      $display("FAIL drop_done: latency %0d port %0d rdata %h want 4 0 %h", lat, port, rdata, exp_rdata);
    end
    exp_bus_q.delete();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL drop_no_retrigger: busy %b want 0", busy);
    end
  endtask

  task automatic test_turnaround0;
    int lat, turns;
    logic [1:0] ph5, by5;
    logic [31:0] e;
    lat = -1; turns = 0; ph5 = 2'd0; by5 = 2'd3;
    din_seed = 8'hC3;
    addr0 = 32'h00000055; we0 = 1'b0; t0_req = 1'b1;
    exp_rd_q.push_back(exp_rd(din_seed));
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (n_bus_phase == 2'd2) turns++;
      if (i == 5) begin ph5 = n_bus_phase; by5 = n_bus_byte; end
      if (n_done0 || n_done1) begin lat = i - 1; t0_req = 1'b0; break; end
    end
    e = exp_rd_q.pop_front();
    n_cmp++;
    if (turns !== 0 || ph5 !== 2'd3 || by5 !== 2'd0) begin
      n_err++;
      $display("FAIL t0_no_turn: turn cycles %0d phase %0d byte %0d after byte 3, want 0 3 0", turns, ph5, by5);
    end
    n_cmp++;
    if (lat !== 8 || n_rdata !== e) begin
      n_err++;
      $display("FAIL t0_read: latency %0d rdata %h want 8 %h", lat, n_rdata, e);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_reset_mid_read();
    test_req_drop();
    test_turnaround0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
